// File: rtl/led_ring_stepper.sv
// Purpose: debounces two raw pushbuttons and steps one lit LED around a 5-LED ring.
// Latency: 2^DB_BITS+3 clk edges from a raw press to the LED/STEP update.
// Backpressure: none. Presses are taken as they are accepted and nothing is queued.
//
// Ports:
//   clk        board clock. All logic is on the rising edge.
//   rst        synchronous, active-high reset.
//   BTN_L      raw left pushbutton, active-high, asynchronous to clk. Steps toward LED5.
//   BTN_R      raw right pushbutton, active-high, asynchronous to clk. Steps toward LED1.
//   LED1..LED5 one-hot ring position, {LED5,LED4,LED3,LED2,LED1} = pos[4:0].
//   STEP       one-cycle pulse, registered together with every position change.
module led_ring_stepper #(
  parameter int DB_BITS = 18
) (
  input  logic clk,
  input  logic rst,
  input  logic BTN_L,
  input  logic BTN_R,
  output logic LED1,
  output logic LED2,
  output logic LED3,
  output logic LED4,
  output logic LED5,
  output logic STEP
);

  // Index 0 is the left button and index 1 is the right button throughout.
  localparam int                 NBTN    = 2;
  localparam logic [DB_BITS-1:0] CNT_MAX = '1;
  localparam logic [DB_BITS-1:0] CNT_ONE = DB_BITS'(1);

  logic [NBTN-1:0]    w_btn_raw;
  logic [NBTN-1:0]    r_s1;
  logic [NBTN-1:0]    r_s2;
  logic [NBTN-1:0]    r_stable;
  logic [NBTN-1:0]    r_stable_q;
  logic [DB_BITS-1:0] r_cnt [NBTN];
  logic [NBTN-1:0]    w_press;

  logic [4:0]         r_pos;
  logic               r_step;
  logic [4:0]         w_pos_nxt;
  logic               w_step_nxt;

  assign w_btn_raw = {BTN_R, BTN_L};

  // Two-flop synchroniser, then a per-button debounce counter.
  // The counter runs only while the synchronised level disagrees with the
  // accepted level. Any agreeing cycle clears it, so a bounce shorter than
  // 2^DB_BITS cycles is never accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= '0;
      r_s2       <= '0;
      r_stable   <= '0;
      r_stable_q <= '0;
      for (int i = 0; i < NBTN; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1       <= w_btn_raw;
      r_s2       <= r_s1;
      r_stable_q <= r_stable;
      for (int i = 0; i < NBTN; i++) begin
        if (r_s2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end else begin
          r_stable[i] <= r_s2[i];
          r_cnt[i]    <= '0;
        end
      end
    end
  end

  // Rising edge of the accepted level only; releases produce no press.
  // r_stable_q resets to 0, so a button held through reset still yields
  // exactly one press once it has been re-debounced.
  assign w_press = r_stable & ~r_stable_q;

  // Presses on the same cycle cancel. Presses on different cycles each step.
  always_comb begin
    w_pos_nxt  = r_pos;
    w_step_nxt = 1'b0;
    case (w_press)
      2'b01: begin
        w_pos_nxt  = {r_pos[3:0], r_pos[4]};
        w_step_nxt = 1'b1;
      end
      2'b10: begin
        w_pos_nxt  = {r_pos[0], r_pos[4:1]};
        w_step_nxt = 1'b1;
      end
      default: begin
        w_pos_nxt  = r_pos;
        w_step_nxt = 1'b0;
      end
    endcase
  end

  // Only rotations are ever loaded, so pos stays one-hot from its reset value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos  <= 5'b00001;
      r_step <= 1'b0;
    end else begin
      r_pos  <= w_pos_nxt;
      r_step <= w_step_nxt;
    end
  end

  assign LED1 = r_pos[0];
  assign LED2 = r_pos[1];
  assign LED3 = r_pos[2];
  assign LED4 = r_pos[3];
  assign LED5 = r_pos[4];
  assign STEP = r_step;

endmodule

// File: tb/tb_led_ring_stepper.sv
module tb_led_ring_stepper;

  localparam int DB = 3;
  localparam int LAT = (1 << DB) + 3;   // 11 edges from a raw press to the step

  typedef struct {
    int         cyc;
    logic [4:0] pos;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic BTN_L, BTN_R;
  logic LED1, LED2, LED3, LED4, LED5, STEP;

  int         cyc = 0;
  int         ncmp = 0;
  int         nerr = 0;
  bit         chk_en = 1'b0;
  logic [4:0] model_pos = 5'b00001;   // position the monitor expects to see
  logic [4:0] sp = 5'b00001;          // position the stimulus is predicting
  exp_t       q[$];

  led_ring_stepper #(.DB_BITS(DB)) dut (
    .clk(clk), .rst(rst), .BTN_L(BTN_L), .BTN_R(BTN_R),
    .LED1(LED1), .LED2(LED2), .LED3(LED3), .LED4(LED4), .LED5(LED5),
    .STEP(STEP)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] rol(input logic [4:0] p);
    return {p[3:0], p[4]};
  endfunction

  function automatic logic [4:0] ror(input logic [4:0] p);
    return {p[0], p[4:1]};
  endfunction

  // Inputs change 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Record a step that a raw edge just driven is expected to cause.
  task automatic expect_step(input logic [4:0] p);
    exp_t e;
    e.cyc = cyc + LAT;
    e.pos = p;
    q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    chk_en = 1'b0;
    rst = 1'b1;
    BTN_L = 1'b0;
    BTN_R = 1'b0;
    tick(n);
    rst = 1'b0;
    sp = 5'b00001;
    model_pos = 5'b00001;
    chk_en = 1'b1;
  endtask

  task automatic press(input bit left, input int hold, input int rel);
    if (left) begin
      BTN_L = 1'b1;
      sp = rol(sp);
    end else begin
      BTN_R = 1'b1;
      sp = ror(sp);
    end
    expect_step(sp);
    tick(hold);
    BTN_L = 1'b0;
    BTN_R = 1'b0;
    tick(rel);
  endtask

  // Monitor: samples on the falling edge and checks against the scoreboard.
  always @(negedge clk) begin
    exp_t       e;
    logic [4:0] leds;
    leds = {LED5, LED4, LED3, LED2, LED1};
    if (STEP === 1'b1) begin
      ncmp++;
      if (q.size() == 0) begin
        nerr++;
        $display("FAIL spurious_step cyc=%0d got STEP=1 leds=%b, required STEP=0", cyc, leds);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || leds !== e.pos) begin
          nerr++;
          $display("FAIL step_event got cyc=%0d leds=%b, required cyc=%0d leds=%b",
                   cyc, leds, e.cyc, e.pos);
        end
        model_pos = e.pos;
      end
    end else if (q.size() != 0 && q[0].cyc <= cyc) begin
      ncmp++;
      nerr++;
      e = q.pop_front();
      $display("FAIL missing_step cyc=%0d got STEP=%b leds=%b, required STEP=1 leds=%b",
               cyc, STEP, leds, e.pos);
      model_pos = e.pos;
    end else if (chk_en) begin
      ncmp++;
      if (leds !== model_pos || STEP !== 1'b0) begin
        nerr++;
        $display("FAIL hold_state cyc=%0d got leds=%b STEP=%b, required leds=%b STEP=0",
                 cyc, leds, STEP, model_pos);
      end
    end
  end

  initial begin
    rst = 1'b1;
    BTN_L = 1'b0;
    BTN_R = 1'b0;

    // Reset with idle buttons: LED1 lit, STEP low.
    do_reset(2);
    tick(4);

    // Single left press held a long time: one step at edge 11, then nothing.
    press(1'b1, LAT + 50, 12);

    // Wrap: five lefts from reset, then one right from 00001.
    do_reset(2);
    tick(2);
    for (int i = 0; i < 5; i++) press(1'b1, 10, 12);
    press(1'b0, 10, 12);

    // Reset in the middle of a debounce count (counter = 5 after 7 edges).
    do_reset(2);
    tick(2);
    BTN_L = 1'b1;
    tick(7);
    do_reset(2);
    tick(15);

    // Bounce rejection on BTN_R, then a clean hold.
    BTN_R = 1'b1; tick(6);
    BTN_R = 1'b0; tick(1);
    BTN_R = 1'b1; tick(6);
    BTN_R = 1'b0; tick(12);
    press(1'b0, 12, 12);

    // Simultaneous presses cancel.
    BTN_L = 1'b1;
    BTN_R = 1'b1;
    tick(14);
    BTN_L = 1'b0;
    BTN_R = 1'b0;
    tick(14);

    // Presses one cycle apart: left then right, back to the start position.
    BTN_L = 1'b1;
    expect_step(rol(sp));
    tick(1);
    BTN_R = 1'b1;
    expect_step(sp);
    tick(14);
    BTN_L = 1'b0;
    BTN_R = 1'b0;
    tick(14);

    // Release gives no step. A later press gives exactly one.
    press(1'b1, 20, 15);
    press(1'b1, 12, 12);

    for (int i = 0; i < 200 && q.size() != 0; i++) tick(1);
    ncmp++;
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL pending_steps got %0d outstanding, required 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
